// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the fetch port, the MEM-stage load/store port,
// the unified RAM port and the pipeline stall outputs of mem_port_arbiter.
//   slave  : arbiter side (drives rdata/ready, ram_*, stall_*)
//   master : environment side (requesters + RAM)
interface mem_port_arbiter_if;
  // fetch port
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  // MEM-stage port (EX/MEM register outputs)
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  // RAM port
  logic        ram_req;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_ack;
  // pipeline freeze
  logic        stall_if;
  logic        stall_mem;

  modport slave (
    input  if_req, if_addr, mem_read, mem_write, mem_addr, mem_wdata,
           ram_rdata, ram_ack,
    output if_rdata, if_ready, mem_rdata, mem_ready,
           ram_req, ram_we, ram_addr, ram_wdata, stall_if, stall_mem
  );

  modport master (
    output if_req, if_addr, mem_read, mem_write, mem_addr, mem_wdata,
           ram_rdata, ram_ack,
    input  if_rdata, if_ready, mem_rdata, mem_ready,
           ram_req, ram_we, ram_addr, ram_wdata, stall_if, stall_mem
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port RAM between instruction fetch and
// the MEM-stage load/store. MEM wins arbitration; each access is registered
// onto the ram_* outputs, held until ram_ack, then answered with a one-cycle
// ready pulse. stall_if / stall_mem freeze the pipeline while waiting.
//
// Ports:
//   clk    clock
//   reset  asynchronous, active-low reset
//   bus    mem_port_arbiter_if.slave (fetch, load/store, RAM, stall signals)
//
// Parameter:
//   STARVE_LIMIT (1..15) consecutive MEM grants tolerated while IF waits
//
// Build option:
//   ARB_FAIRNESS_EN  when defined, a starvation counter forces an IF grant
//                    after STARVE_LIMIT back-to-back MEM grants; when
//                    undefined, MEM has strict priority.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input logic          clk,
  input logic          reset,
  mem_port_arbiter_if.slave bus
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("mem_port_arbiter: STARVE_LIMIT must be in 1..15");
  end

  typedef enum logic [2:0] {IDLE, BUSY_IF, BUSY_MEM, RESP_IF, RESP_MEM} state_t;

  state_t state, state_nxt;
  logic   mem_pend;
  logic   grant_if;
  logic   grant_mem;
  logic   if_force;

  assign mem_pend = bus.mem_read | bus.mem_write;

`ifdef ARB_FAIRNESS_EN
  // Counts MEM grants taken while IF was waiting; reaching the limit hands
  // the next contested slot to IF.
  logic [3:0] starve_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         starve_cnt <= '0;
    else if (grant_if)  starve_cnt <= '0;
    else if (grant_mem) starve_cnt <= bus.if_req ? starve_cnt + 4'd1 : 4'd0;
  end

  assign if_force = bus.if_req & mem_pend & (starve_cnt == 4'(STARVE_LIMIT));
`else
  assign if_force = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_mem = 1'b0;
    case (state)
      IDLE: begin
        if (if_force) begin
          grant_if  = 1'b1;
          state_nxt = BUSY_IF;
        end else if (mem_pend) begin
          grant_mem = 1'b1;
          state_nxt = BUSY_MEM;
        end else if (bus.if_req) begin
          grant_if  = 1'b1;
          state_nxt = BUSY_IF;
        end
      end
      BUSY_IF:  if (bus.ram_ack) state_nxt = RESP_IF;
      BUSY_MEM: if (bus.ram_ack) state_nxt = RESP_MEM;
      RESP_IF:  state_nxt = IDLE;
      RESP_MEM: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // RAM request registers: loaded on grant, frozen until ram_ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.ram_req   <= 1'b0;
      bus.ram_we    <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_wdata <= '0;
    end else if (grant_mem) begin
      bus.ram_req   <= 1'b1;
      bus.ram_we    <= bus.mem_write;  // read+write together acts as a store
      bus.ram_addr  <= bus.mem_addr;
      bus.ram_wdata <= bus.mem_wdata;
    end else if (grant_if) begin
      bus.ram_req   <= 1'b1;
      bus.ram_we    <= 1'b0;
      bus.ram_addr  <= bus.if_addr;
    end else if ((state == BUSY_IF || state == BUSY_MEM) && bus.ram_ack) begin
      bus.ram_req   <= 1'b0;
      bus.ram_we    <= 1'b0;
    end
  end

  // Read data capture; a store leaves mem_rdata untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.if_rdata  <= '0;
      bus.mem_rdata <= '0;
    end else if (bus.ram_ack) begin
      if (state == BUSY_IF)                  bus.if_rdata  <= bus.ram_rdata;
      if (state == BUSY_MEM && !bus.ram_we)  bus.mem_rdata <= bus.ram_rdata;
    end
  end

  assign bus.if_ready  = (state == RESP_IF);
  assign bus.mem_ready = (state == RESP_MEM);

  assign bus.stall_if  = bus.if_req & ~bus.if_ready;
  assign bus.stall_mem = mem_pend & ~bus.mem_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();
  mem_port_arbiter #(.STARVE_LIMIT(2)) dut (.clk(clk), .reset(reset), .bus(bus));

`ifdef ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif
  localparam int LIMIT = 2;

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] ref_mem [logic [31:0]];   // reference memory contents
  logic [31:0] ram_arr [logic [31:0]];   // storage of the RAM model
  logic [31:0] if_q[$];
  logic [31:0] mem_q[$];
  int          grant_log[$];             // 0 = IF, 1 = MEM
  logic [31:0] cur_if_addr, cur_mem_addr, cur_mem_wdata, last_load;
  logic        cur_mem_we;
  int          delay_cfg;                // <0: random 0..3 wait cycles

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // RAM model: acks after a configurable number of extra cycles and checks
  // that the request it sees matches what the requester asked for.
  initial begin : responder
    bit in_acc;
    int wait_n;
    int port;
    in_acc = 0; wait_n = 0;
    bus.ram_ack = 1'b0; bus.ram_rdata = '0;
    forever begin
      @(posedge clk); #1;
      bus.ram_ack = 1'b0;
      if (!bus.ram_req) in_acc = 0;
      else begin
        port = (bus.ram_addr >= 32'h100) ? 1 : 0;
        if (!in_acc) begin
          in_acc = 1;
          grant_log.push_back(port);
          wait_n = (delay_cfg < 0) ? int'($urandom_range(0, 3)) : delay_cfg;
        end
        if (port == 1) begin
          check("ram_addr_mem", bus.ram_addr, cur_mem_addr);
          check("ram_we_mem", 32'(bus.ram_we), 32'(cur_mem_we));
          if (cur_mem_we) check("ram_wdata", bus.ram_wdata, cur_mem_wdata);
        end else begin
          check("ram_addr_if", bus.ram_addr, cur_if_addr);
          check("ram_we_if", 32'(bus.ram_we), 32'd0);
        end
        if (wait_n == 0) begin
          bus.ram_ack = 1'b1;
          if (bus.ram_we) ram_arr[bus.ram_addr] = bus.ram_wdata;
          else bus.ram_rdata = ram_arr.exists(bus.ram_addr) ? ram_arr[bus.ram_addr]
                                                            : dflt(bus.ram_addr);
          in_acc = 0;
        end else wait_n--;
      end
    end
  end

  // Monitor: pops expectations whenever a ready pulse appears.
  always @(negedge clk) begin
    if (reset) begin
      check("stall_if", 32'(bus.stall_if), 32'(bus.if_req & ~bus.if_ready));
      check("stall_mem", 32'(bus.stall_mem),
            32'((bus.mem_read | bus.mem_write) & ~bus.mem_ready));
      if (bus.if_ready) begin
        if (if_q.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL if_ready_unexpected: got pulse, expected none (t=%0t)", $time);
        end else check("if_rdata", bus.if_rdata, if_q.pop_front());
      end
      if (bus.mem_ready) begin
        if (mem_q.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL mem_ready_unexpected: got pulse, expected none (t=%0t)", $time);
        end else check("mem_rdata", bus.mem_rdata, mem_q.pop_front());
      end
    end
  end

  task automatic wait_ready(input bit is_mem, output int lat);
    lat = 0;
    forever begin
      @(posedge clk); #1;
      lat++;
      if ((is_mem ? bus.mem_ready : bus.if_ready) == 1'b1) break;
      if (lat >= 1000) begin
        n_checks++; n_err++;
        $display("FAIL %s_timeout: got no ready, expected one within 1000 cycles",
                 is_mem ? "mem" : "if");
        break;
      end
    end
  endtask

  task automatic if_access(input logic [31:0] a, output int lat);
    cur_if_addr = a;
    if_q.push_back(ref_rd(a));
    bus.if_addr = a;
    bus.if_req  = 1'b1;
    wait_ready(1'b0, lat);
    bus.if_req  = 1'b0;
  endtask

  task automatic mem_access(input bit rd, input bit wr, input logic [31:0] a,
                            input logic [31:0] d, output int lat);
    cur_mem_addr  = a;
    cur_mem_wdata = d;
    cur_mem_we    = wr;
    if (wr) ref_mem[a] = d;
    else    last_load = ref_rd(a);
    mem_q.push_back(last_load);
    bus.mem_addr  = a;
    bus.mem_wdata = d;
    bus.mem_read  = rd;
    bus.mem_write = wr;
    wait_ready(1'b1, lat);
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ram_req"},   32'(bus.ram_req), 32'd0);
    check({tag, "_ram_we"},    32'(bus.ram_we), 32'd0);
    check({tag, "_if_ready"},  32'(bus.if_ready), 32'd0);
    check({tag, "_mem_ready"}, 32'(bus.mem_ready), 32'd0);
    check({tag, "_ram_addr"},  bus.ram_addr, 32'd0);
    check({tag, "_ram_wdata"}, bus.ram_wdata, 32'd0);
    check({tag, "_if_rdata"},  bus.if_rdata, 32'd0);
    check({tag, "_mem_rdata"}, bus.mem_rdata, 32'd0);
  endtask

  initial begin : main
    int lat_i, lat_m, lat;
    int exp_order[$];
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;
    cur_if_addr = '0; cur_mem_addr = '0; cur_mem_wdata = '0; cur_mem_we = 1'b0;
    last_load = '0; delay_cfg = 0;
    ref_mem[32'h40]  = 32'h8C22_0004; ram_arr[32'h40]  = 32'h8C22_0004;
    ref_mem[32'h200] = 32'h0000_1234; ram_arr[32'h200] = 32'h0000_1234;

    idle(3);
    check_reset_outputs("rst");
    reset = 1'b1;
    idle(1);

    // single fetch, RAM acks on first request cycle
    delay_cfg = 0;
    if_access(32'h40, lat);
    check("fetch_latency", 32'(lat), 32'd2);
    idle(2);

    // store, ack after 3 request cycles; mem_rdata must stay 0
    delay_cfg = 2;
    mem_access(1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, lat);
    check("store_latency", 32'(lat), 32'd4);
    idle(2);

    // simultaneous fetch and load: MEM first, IF at the following IDLE
    delay_cfg = 0;
    grant_log.delete();
    fork
      mem_access(1'b1, 1'b0, 32'h200, 32'h0, lat_m);
      if_access(32'h44, lat_i);
    join
    check("sim_mem_latency", 32'(lat_m), 32'd2);
    check("sim_if_latency", 32'(lat_i), 32'd5);
    check("sim_grant_cnt", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() >= 2) begin
      check("sim_grant0", 32'(grant_log[0]), 32'd1);
      check("sim_grant1", 32'(grant_log[1]), 32'd0);
    end
    idle(2);

    // reset in the middle of a slow load
    delay_cfg = 20;
    cur_mem_addr = 32'h1010; cur_mem_we = 1'b0;
    bus.mem_addr = 32'h1010; bus.mem_read = 1'b1;
    for (int k = 0; k < 10 && !bus.ram_req; k++) idle(1);
    idle(1);
    #2 reset = 1'b0;
    #1 check_reset_outputs("midrst");
    last_load = '0;
    idle(2);
    reset = 1'b1;
    delay_cfg = 0;
    mem_access(1'b1, 1'b0, 32'h1010, 32'h0, lat);
    check("post_reset_latency", 32'(lat), 32'd2);
    idle(2);

    // starvation: IF held while MEM re-requests right after each ready
    grant_log.delete();
    fork
      if_access(32'h48, lat_i);
      for (int k = 0; k < 4; k++) mem_access(1'b1, 1'b0, 32'h1020 + 32'(k * 4), 32'h0, lat_m);
    join
    begin
      int starve = 0, mems_left = 4;
      bit if_pend = 1'b1;
      while (mems_left > 0 || if_pend) begin
        if (if_pend && (mems_left == 0 || (FAIR && starve == LIMIT))) begin
          exp_order.push_back(0); if_pend = 1'b0; starve = 0;
        end else begin
          exp_order.push_back(1); mems_left--; starve = if_pend ? starve + 1 : 0;
        end
      end
    end
    check("fair_grant_cnt", 32'(grant_log.size()), 32'(exp_order.size()));
    for (int k = 0; k < exp_order.size() && k < grant_log.size(); k++)
      check($sformatf("fair_grant%0d", k), 32'(grant_log[k]), 32'(exp_order[k]));
    idle(2);

    // randomized traffic from both ports with random RAM latency
    delay_cfg = -1;
    fork
      for (int k = 0; k < 40; k++) begin
        int l;
        idle(int'($urandom_range(0, 3)));
        if_access(32'($urandom_range(0, 63)) << 2, l);
      end
      for (int k = 0; k < 80; k++) begin
        int l, r;
        logic [31:0] a;
        idle(int'($urandom_range(0, 2)));
        r = int'($urandom_range(0, 3));
        a = 32'h1000 + (32'($urandom_range(0, 15)) << 2);
        mem_access(r != 2, r >= 2, a, $urandom, l);
      end
    join
    idle(3);
    check("if_q_drained", 32'(if_q.size()), 32'd0);
    check("mem_q_drained", 32'(mem_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port unified RAM between instruction fetch (IF) and the MEM stage load/store, which is driven from the EX/MEM pipeline register outputs. Each access uses a request/acknowledge handshake, and the block returns a one-cycle ready pulse to the requester. It generates the stall signals that freeze the pipeline registers while an access is outstanding. MEM-stage requests have priority over fetch, with an optional starvation guard.

## Interface
- STARVE_LIMIT, 4: consecutive MEM grants allowed while IF is waiting before IF is forced (fairness build only); range 1–15.
- clk  input  1  clock.
- reset  input  1  reset, asynchronous, active-low.
- if_req  input  1  fetch request; held until if_ready.
- if_addr  input  32  fetch address.
- if_rdata  output  32  fetched instruction, registered.
- if_ready  output  1  one-cycle completion pulse for fetch.
- mem_read  input  1  load request from the EX/MEM register.
- mem_write  input  1  store request from the EX/MEM register.
- mem_addr  input  32  load/store address (EX/MEM ALU result).
- mem_wdata  input  32  store data (EX/MEM busB).
- mem_rdata  output  32  load data, registered.
- mem_ready  output  1  one-cycle completion pulse for load/store.
- ram_req  output  1  RAM request, registered.
- ram_we  output  1  RAM write enable, registered.
- ram_addr  output  32  RAM address, registered.
- ram_wdata  output  32  RAM write data, registered.
- ram_rdata  input  32  RAM read data, valid on ram_ack.
- ram_ack  input  1  RAM completion; sampled only while ram_req=1.
- stall_if  output  1  combinational: if_req & ~if_ready.
- stall_mem  output  1  combinational: (mem_read|mem_write) & ~mem_ready.

## Operation
- States: IDLE, BUSY_IF, BUSY_MEM, RESP_IF, RESP_MEM.
- IDLE arbitration:
  - MEM request (mem_read|mem_write) pending → BUSY_MEM.
  - Else if_req → BUSY_IF.
  - Else stay in IDLE.
- On grant, register the request into the ram_* outputs:
  - Set ram_req=1.
  - ram_we = mem_write for MEM grants, 0 for IF grants.
  - mem_read and mem_write both high → treated as a write.
- ram_addr, ram_wdata and ram_we stay stable until ram_ack.
- BUSY_x with ram_ack=1:
  - Clear ram_req and ram_we.
  - IF or MEM load: capture ram_rdata into if_rdata / mem_rdata.
  - Store: mem_rdata holds its previous value.
  - Go to RESP_x.
- BUSY_x with ram_ack=0: hold state and all outputs.
- RESP_x: x_ready=1 for exactly this cycle, then → IDLE unconditionally. The requester drops or changes its request in this cycle, so it is never re-granted spuriously.
- Requesters hold address and data stable from request until ready.
- A request withdrawn while in BUSY_x is not supported; the access completes anyway.
- Reset (asynchronous, any state):
  - State → IDLE.
  - ram_req, ram_we, if_ready, mem_ready → 0.
  - ram_addr, ram_wdata, if_rdata, mem_rdata → 0.
  - Starvation counter → 0.
  - An in-flight RAM access is abandoned.

## Timing
- Request sampled at edge t0 in IDLE → ram_req high after t0.
- ram_ack at edge t1 (t1 ≥ t0+1) → ready high during cycle t1..t1+1.
- Arbiter back in IDLE after edge t1+1.
- Minimum turnaround: 3 cycles per access (grant, ack, resp).
- Both requests pending in IDLE → MEM served first. IF is granted at the IDLE following RESP_MEM, provided no new MEM request is pending (strict build).
- Stall outputs are combinational and deassert in the ready cycle, so the pipeline registers advance at the end of that cycle.

## Configuration
- ARB_FAIRNESS_EN defined:
  - A 4-bit counter increments on each MEM grant made while if_req=1.
  - The counter clears on any IF grant, or on a MEM grant made while if_req=0.
  - When counter == STARVE_LIMIT and both requests are pending, IF is granted.
- ARB_FAIRNESS_EN undefined: strict MEM priority; no counter logic is present.

## Test plan
- Single fetch with 1-cycle RAM: if_req=1, if_addr=0x40, ram_ack on the first ram_req cycle with ram_rdata=0x8C220004 → if_ready pulses one cycle later, if_rdata=0x8C220004, ram_we=0 throughout.
- Store with 3-cycle ack delay: mem_write=1, mem_addr=0x100, mem_wdata=0xDEADBEEF:
  - ram_addr=0x100, ram_wdata=0xDEADBEEF and ram_we=1 are held stable for 3 cycles.
  - stall_mem=1 until the mem_ready pulse.
  - mem_rdata is unchanged.
- Simultaneous if_req and mem_read (addr 0x200, data 0x1234):
  - MEM is served first; mem_rdata=0x1234.
  - The IF grant begins at the IDLE following RESP_MEM.
  - stall_if stays high throughout.
- Reset asserted while in BUSY_MEM → ram_req=0 and all outputs 0 immediately. After release with mem_read held, a fresh grant is issued.
- Fairness, with ARB_FAIRNESS_EN and STARVE_LIMIT=2; if_req held while mem_read is re-requested after every RESP_MEM:
  - Grant order is MEM, MEM, IF, MEM.
  - Without the macro, IF is never granted while MEM keeps requesting.
